// File: rtl/seg_scan_ctrl.sv
// Multiplexed 4-digit 7-segment scan controller with per-slot PWM brightness and frame-latched data.
// Optional leading-zero blanking is enabled by defining LEAD_ZERO_BLANK_EN.
module seg_scan_ctrl #(
  parameter bit AN_ACT_LOW  = 1'b1,
  parameter bit SEG_ACT_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        run,
  input  logic [1:0]  light,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_in,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_start
);

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_SCAN  = 2'd1,
    ST_GUARD = 2'd2
  } state_t;

  localparam logic [3:0] AN_OFF  = AN_ACT_LOW  ? 4'hF  : 4'h0;
  localparam logic [6:0] SEG_OFF = SEG_ACT_LOW ? 7'h7F : 7'h00;
  localparam logic       DP_OFF  = SEG_ACT_LOW;

  state_t      state_q, state_d;
  logic [1:0]  dig_idx_q, dig_idx_d;
  logic [1:0]  phase_q, phase_d;
  logic [15:0] digits_lat_q, digits_lat_d;
  logic [3:0]  dp_lat_q, dp_lat_d;
  logic [3:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;
  logic        frame_start_q, frame_start_d;

  logic [3:0]  lit_en;
  logic [3:0]  nibble;
  logic [6:0]  seg_hi;
  logic        dp_hi;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] p;
    unique case (n)
      4'h0: p = 7'h3F;
      4'h1: p = 7'h06;
      4'h2: p = 7'h5B;
      4'h3: p = 7'h4F;
      4'h4: p = 7'h66;
      4'h5: p = 7'h6D;
      4'h6: p = 7'h7D;
      4'h7: p = 7'h07;
      4'h8: p = 7'h7F;
      4'h9: p = 7'h6F;
      4'hA: p = 7'h77;
      4'hB: p = 7'h7C;
      4'hC: p = 7'h39;
      4'hD: p = 7'h5E;
      4'hE: p = 7'h79;
      default: p = 7'h71;
    endcase
    return p;
  endfunction

  always_comb begin
    state_d       = state_q;
    dig_idx_d     = dig_idx_q;
    phase_d       = phase_q;
    digits_lat_d  = digits_lat_q;
    dp_lat_d      = dp_lat_q;
    frame_start_d = 1'b0;

    unique case (state_q)
      ST_OFF: begin
        if (run) begin
          state_d       = ST_SCAN;
          digits_lat_d  = digits;
          dp_lat_d      = dp_in;
          frame_start_d = 1'b1;
        end
      end
      ST_SCAN: begin
        if (tick) begin
          phase_d = phase_q + 2'd1;
          if (phase_q == 2'd3) begin
            dig_idx_d = dig_idx_q + 2'd1;
            state_d   = ST_GUARD;
            if (dig_idx_q == 2'd3) begin
              digits_lat_d  = digits;
              dp_lat_d      = dp_in;
              frame_start_d = 1'b1;
            end
          end
        end
      end
      ST_GUARD: state_d = ST_SCAN;
      default:  state_d = ST_OFF;
    endcase

    // Stopping the scan beats any tick or frame latch in the same cycle.
    if (!run) begin
      state_d       = ST_OFF;
      dig_idx_d     = 2'd0;
      phase_d       = 2'd0;
      digits_lat_d  = digits_lat_q;
      dp_lat_d      = dp_lat_q;
      frame_start_d = 1'b0;
    end
  end

`ifdef LEAD_ZERO_BLANK_EN
  logic [3:0] blank;
  always_comb begin
    blank    = 4'b0000;
    blank[3] = (digits_lat_d[15:12] == 4'h0) && !dp_lat_d[3];
    blank[2] = blank[3] && (digits_lat_d[11:8] == 4'h0) && !dp_lat_d[2];
    blank[1] = blank[2] && (digits_lat_d[7:4]  == 4'h0) && !dp_lat_d[1];
  end
`endif

  // Outputs are computed from next-state values so the registered pins line up with the state.
  always_comb begin
    lit_en = 4'b0000;
    if ((state_d == ST_SCAN) && (phase_d <= light)) lit_en[dig_idx_d] = 1'b1;
`ifdef LEAD_ZERO_BLANK_EN
    lit_en = lit_en & ~blank;
`endif
    nibble = digits_lat_d[{dig_idx_d, 2'b00} +: 4];
    seg_hi = (state_d == ST_OFF) ? 7'h00 : hex7(nibble);
    dp_hi  = (state_d == ST_OFF) ? 1'b0  : dp_lat_d[dig_idx_d];
    an_d   = AN_ACT_LOW  ? ~lit_en : lit_en;
    seg_d  = SEG_ACT_LOW ? ~seg_hi : seg_hi;
    dp_d   = SEG_ACT_LOW ? ~dp_hi  : dp_hi;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_OFF;
      dig_idx_q     <= 2'd0;
      phase_q       <= 2'd0;
      digits_lat_q  <= 16'h0000;
      dp_lat_q      <= 4'h0;
      an_q          <= AN_OFF;
      seg_q         <= SEG_OFF;
      dp_q          <= DP_OFF;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      dig_idx_q     <= dig_idx_d;
      phase_q       <= phase_d;
      digits_lat_q  <= digits_lat_d;
      dp_lat_q      <= dp_lat_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign dp          = dp_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: hand-derived vector table, directed frame/stop/blanking sequences,
// and random stimulus against a frame-position reference model (honours LEAD_ZERO_BLANK_EN).
module tb_seg_scan_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic        run = 1'b0;
  logic [1:0]  light = 2'd3;
  logic [15:0] digits = 16'h0000;
  logic [3:0]  dp_in = 4'h0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_start;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  seg_scan_ctrl dut (
    .clk(clk), .rst(rst), .tick(tick), .run(run), .light(light),
    .digits(digits), .dp_in(dp_in), .an(an), .seg(seg), .dp(dp),
    .frame_start(frame_start)
  );

  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference: position within a 16-tick frame, plus a pending guard cycle flag.
  bit          m_on = 0;
  int          m_pos = 0;
  bit          m_guard = 0;
  bit          m_fs = 0;
  logic [15:0] m_dig = 16'h0;
  logic [3:0]  m_dp = 4'h0;
  logic [3:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_dp;

  function automatic bit m_blank(int d);
`ifdef LEAD_ZERO_BLANK_EN
    if (d == 0) return 1'b0;
    for (int k = d; k < 4; k++)
      if (m_dig[4*k +: 4] != 4'h0 || m_dp[k]) return 1'b0;
    return 1'b1;
`else
    return (d < 0);
`endif
  endfunction

  task automatic model_step(input bit r, input bit ru, input bit tk, input logic [1:0] li,
                            input logic [15:0] dg, input logic [3:0] dpi);
    int d;
    int p;
    m_fs = 0;
    if (r) begin
      m_on = 0; m_pos = 0; m_guard = 0; m_dig = 16'h0; m_dp = 4'h0;
    end else if (!ru) begin
      m_on = 0; m_pos = 0; m_guard = 0;
    end else if (!m_on) begin
      m_on = 1; m_pos = 0; m_guard = 0; m_dig = dg; m_dp = dpi; m_fs = 1;
    end else if (m_guard) begin
      m_guard = 0;
    end else if (tk) begin
      m_pos = (m_pos + 1) % 16;
      if (m_pos % 4 == 0) begin
        m_guard = 1;
        if (m_pos == 0) begin
          m_dig = dg; m_dp = dpi; m_fs = 1;
        end
      end
    end
    exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
    if (m_on) begin
      d = m_pos / 4;
      p = m_pos % 4;
      exp_seg = ~hex_tab[m_dig[4*d +: 4]];
      exp_dp  = ~m_dp[d];
      if (!m_guard && p <= int'(li) && !m_blank(d)) exp_an[d] = 1'b0;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic step(input bit r, input bit ru, input bit tk, input logic [1:0] li,
                      input logic [15:0] dg, input logic [3:0] dpi);
    rst = r; run = ru; tick = tk; light = li; digits = dg; dp_in = dpi;
    @(posedge clk);
    model_step(r, ru, tk, li, dg, dpi);
    #1;
    check("model_an", {28'h0, an}, {28'h0, exp_an});
    check("model_seg", {25'h0, seg}, {25'h0, exp_seg});
    check("model_dp", {31'h0, dp}, {31'h0, exp_dp});
    check("model_fs", {31'h0, frame_start}, {31'h0, m_fs});
  endtask

  typedef struct packed {
    logic        r, ru, tk;
    logic [1:0]  li;
    logic [15:0] dg;
    logic [3:0]  dpi;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp, fs;
  } vec_t;

  vec_t vecs [13];

  logic [3:0] slot_an  [5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
  logic [6:0] slot_seg [5] = '{7'h19, 7'h30, 7'h24, 7'h79, 7'h00};
  logic [3:0] an_seq [$];
  logic [3:0] prev_an;
  int         guard_cnt, an3_low, an2_low, zero_bad, d1_bad;
  bit         last_tick;
  logic [1:0] r_li;
  logic [15:0] r_dg;
  logic [3:0] r_dp;
  bit         r_run;

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 2'd3, 16'h1234, 4'h0, 4'hF, 7'h7F, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 2'd3, 16'h1234, 4'h0, 4'hE, 7'h19, 1'b1, 1'b1};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 2'd3, 16'h1234, 4'h0, 4'hE, 7'h19, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 2'd3, 16'h1234, 4'h0, 4'hE, 7'h19, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 2'd3, 16'h1234, 4'h0, 4'hE, 7'h19, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 2'd3, 16'h1234, 4'h0, 4'hE, 7'h19, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 2'd3, 16'h1234, 4'h0, 4'hF, 7'h30, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 2'd3, 16'h1234, 4'h0, 4'hD, 7'h30, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 2'd3, 16'h1234, 4'h0, 4'hF, 7'h7F, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 2'd0, 16'h00A5, 4'h1, 4'hE, 7'h12, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 2'd0, 16'h00A5, 4'h1, 4'hF, 7'h12, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 2'd2, 16'h00A5, 4'h1, 4'hE, 7'h12, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 1'b1, 2'd3, 16'h00A5, 4'h1, 4'hF, 7'h7F, 1'b1, 1'b0};

    for (int i = 0; i < 13; i++) begin
      step(vecs[i].r, vecs[i].ru, vecs[i].tk, vecs[i].li, vecs[i].dg, vecs[i].dpi);
      check($sformatf("vec%0d", i), {19'h0, an, seg, dp, frame_start},
            {19'h0, vecs[i].an, vecs[i].seg, vecs[i].dp, vecs[i].fs});
    end

    // Scan order, guard count, mid-frame data change and frame_start at the wrap.
    step(1, 0, 0, 3, 16'h1234, 0);
    step(0, 1, 0, 3, 16'h1234, 0);
    guard_cnt = 0;
    prev_an = an;
    an_seq.push_back(an);
    for (int t = 0; t < 17; t++) begin
      for (int i = 0; i < 3; i++) begin
        step(0, 1, 0, 3, (t >= 4) ? 16'h5678 : 16'h1234, 0);
        if (i == 0 && t % 4 == 0) begin
          check($sformatf("slot%0d_an", t / 4), {28'h0, an}, {28'h0, slot_an[t / 4]});
          check($sformatf("slot%0d_seg", t / 4), {25'h0, seg}, {25'h0, slot_seg[t / 4]});
        end
        if (an != prev_an && an != 4'hF) an_seq.push_back(an);
        if (an != 4'hF) prev_an = an;
        if (an == 4'hF) guard_cnt++;
      end
      if (t == 16) break;
      step(0, 1, 1, 3, (t >= 4) ? 16'h5678 : 16'h1234, 0);
      if (an == 4'hF) guard_cnt++;
      if (t == 15) check("wrap_frame_start", {31'h0, frame_start}, 32'h1);
      if (t == 7) check("midframe_no_fs", {31'h0, frame_start}, 32'h0);
    end
    check("guard_cycles", guard_cnt, 4);
    check("an_seq_len", an_seq.size(), 5);
    for (int i = 0; i < 5 && i < an_seq.size(); i++)
      check($sformatf("an_seq%0d", i), {28'h0, an_seq[i]}, {28'h0, slot_an[i]});

    // Stop coinciding with a tick, then restart.
    step(0, 1, 1, 3, 16'h1234, 0);
    step(0, 0, 1, 3, 16'h1234, 0);
    check("stop_an", {28'h0, an}, 32'hF);
    check("stop_seg", {25'h0, seg}, 32'h7F);
    step(0, 1, 0, 3, 16'h1234, 0);
    check("restart_fs", {31'h0, frame_start}, 32'h1);
    check("restart_an", {28'h0, an}, 32'hE);
    check("restart_seg", {25'h0, seg}, 32'h19);

    // Leading zeros.
    step(1, 0, 0, 3, 16'h0042, 0);
    step(0, 1, 0, 3, 16'h0042, 0);
    an3_low = 0; an2_low = 0; zero_bad = 0; d1_bad = 0;
    for (int t = 0; t < 16; t++) begin
      for (int i = 0; i < 4; i++) begin
        step(0, 1, (i == 3), 3, 16'h0042, 0);
        if (!an[3]) an3_low++;
        if (!an[2]) an2_low++;
        if ((an == 4'b0111 || an == 4'b1011) && seg != 7'h40) zero_bad++;
        if (an == 4'b1101 && seg != 7'h19) d1_bad++;
      end
    end
`ifdef LEAD_ZERO_BLANK_EN
    check("lz_an3_never_low", an3_low, 0);
    check("lz_an2_never_low", an2_low, 0);
`else
    check("an3_lit_cycles", an3_low, 15);
    check("an2_lit_cycles", an2_low, 15);
`endif
    check("zero_digit_seg", zero_bad, 0);
    check("digit1_seg", d1_bad, 0);

    // Random stimulus against the model; ticks never back-to-back.
    last_tick = 0; r_li = 2'd3; r_dg = 16'h1234; r_dp = 4'h0; r_run = 1;
    for (int n = 0; n < 4000; n++) begin
      bit r, tk;
      r = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 149) == 0) r_run = ~r_run;
      else if (!r_run && $urandom_range(0, 9) == 0) r_run = 1;
      tk = !last_tick && ($urandom_range(0, 2) == 0);
      last_tick = tk;
      if ($urandom_range(0, 19) == 0) r_li = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) r_dg = 16'($urandom);
      if ($urandom_range(0, 29) == 0) r_dp = 4'($urandom);
      if ($urandom_range(0, 39) == 0) r_dg = {8'h00, 8'($urandom)};
      step(r, r_run, tk, r_li, r_dg, r_dp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
